// File: rtl/bp_cce_msg_mode_switch_pkg.sv
// Shared types and helpers for the CCE message-engine mode switch.
package bp_cce_msg_mode_switch_pkg;

    typedef enum logic [1:0] {
        e_ms_run    = 2'd0,
        e_ms_drain  = 2'd1,
        e_ms_switch = 2'd2
    } bp_cce_mode_switch_state_e;

    // Index width that stays at least one bit even for a single engine.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_cce_msg_mode_switch_if.sv
// CCE-side message channels plus their per-engine mirrors, bundled for the mode switch.
interface bp_cce_msg_mode_switch_if #(
    parameter int num_engines_p    = 2,
    parameter int lce_req_width_p  = 64,
    parameter int lce_resp_width_p = 64,
    parameter int lce_cmd_width_p  = 64,
    parameter int mem_msg_width_p  = 128
);
    logic [lce_req_width_p-1:0]  lce_req;
    logic                        lce_req_v;
    logic                        lce_req_yumi;
    logic [lce_resp_width_p-1:0] lce_resp;
    logic                        lce_resp_v;
    logic                        lce_resp_yumi;
    logic [mem_msg_width_p-1:0]  mem_resp;
    logic                        mem_resp_v;
    logic                        mem_resp_yumi;
    logic [lce_cmd_width_p-1:0]  lce_cmd;
    logic                        lce_cmd_v;
    logic                        lce_cmd_ready;
    logic [mem_msg_width_p-1:0]  mem_cmd;
    logic                        mem_cmd_v;
    logic                        mem_cmd_ready;

    logic [num_engines_p-1:0][lce_req_width_p-1:0]  eng_lce_req;
    logic [num_engines_p-1:0]                       eng_lce_req_v;
    logic [num_engines_p-1:0]                       eng_lce_req_yumi;
    logic [num_engines_p-1:0][lce_resp_width_p-1:0] eng_lce_resp;
    logic [num_engines_p-1:0]                       eng_lce_resp_v;
    logic [num_engines_p-1:0]                       eng_lce_resp_yumi;
    logic [num_engines_p-1:0][mem_msg_width_p-1:0]  eng_mem_resp;
    logic [num_engines_p-1:0]                       eng_mem_resp_v;
    logic [num_engines_p-1:0]                       eng_mem_resp_yumi;
    logic [num_engines_p-1:0][lce_cmd_width_p-1:0]  eng_lce_cmd;
    logic [num_engines_p-1:0]                       eng_lce_cmd_v;
    logic [num_engines_p-1:0]                       eng_lce_cmd_ready;
    logic [num_engines_p-1:0][mem_msg_width_p-1:0]  eng_mem_cmd;
    logic [num_engines_p-1:0]                       eng_mem_cmd_v;
    logic [num_engines_p-1:0]                       eng_mem_cmd_ready;

    // master: the switch itself; slave: the surrounding FIFOs and engines
    modport master (
        input  lce_req, lce_req_v, lce_resp, lce_resp_v, mem_resp, mem_resp_v,
        input  lce_cmd_ready, mem_cmd_ready,
        input  eng_lce_req_yumi, eng_lce_resp_yumi, eng_mem_resp_yumi,
        input  eng_lce_cmd, eng_lce_cmd_v, eng_mem_cmd, eng_mem_cmd_v,
        output lce_req_yumi, lce_resp_yumi, mem_resp_yumi,
        output lce_cmd, lce_cmd_v, mem_cmd, mem_cmd_v,
        output eng_lce_req, eng_lce_req_v, eng_lce_resp, eng_lce_resp_v,
        output eng_mem_resp, eng_mem_resp_v, eng_lce_cmd_ready, eng_mem_cmd_ready
    );

    modport slave (
        output lce_req, lce_req_v, lce_resp, lce_resp_v, mem_resp, mem_resp_v,
        output lce_cmd_ready, mem_cmd_ready,
        output eng_lce_req_yumi, eng_lce_resp_yumi, eng_mem_resp_yumi,
        output eng_lce_cmd, eng_lce_cmd_v, eng_mem_cmd, eng_mem_cmd_v,
        input  lce_req_yumi, lce_resp_yumi, mem_resp_yumi,
        input  lce_cmd, lce_cmd_v, mem_cmd, mem_cmd_v,
        input  eng_lce_req, eng_lce_req_v, eng_lce_resp, eng_lce_resp_v,
        input  eng_mem_resp, eng_mem_resp_v, eng_lce_cmd_ready, eng_mem_cmd_ready
    );
endinterface

// File: rtl/bp_cce_msg_mode_switch_outstanding_counter.sv
// Up/down count of in-flight memory commands with a saturation flag.
module bp_cce_msg_mode_switch_outstanding_counter #(
    parameter  int max_outstanding_p = 8,
    localparam int width_lp          = $clog2(max_outstanding_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [width_lp-1:0] count_o,
    output logic                full_o
);
    logic [width_lp-1:0] count_q, count_d;

    assign full_o  = (count_q == width_lp'(max_outstanding_p));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + width_lp'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A response with nothing outstanding means an engine yumi'd something it never asked for.
    underflow_a: assert property (@(posedge clk_i) disable iff (reset_i) !(dec_i && (count_q == '0)));

endmodule

// File: rtl/bp_cce_msg_mode_switch.sv
// Routes CCE message channels to the active engine and sequences drain-then-switch mode changes.
module bp_cce_msg_mode_switch
    import bp_cce_msg_mode_switch_pkg::*;
#(
    parameter  int num_engines_p     = 2,
    parameter  int lce_req_width_p   = 64,
    parameter  int lce_resp_width_p  = 64,
    parameter  int lce_cmd_width_p   = 64,
    parameter  int mem_msg_width_p   = 128,
    parameter  int max_outstanding_p = 8,
    parameter  int reset_mode_p      = 0,
    localparam int lg_e_lp           = safe_clog2(num_engines_p),
    localparam int cnt_width_lp      = $clog2(max_outstanding_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [lg_e_lp-1:0]       mode_req_i,
    input  logic                     mode_req_v_i,
    output logic                     mode_req_ready_o,
    output logic [lg_e_lp-1:0]       active_mode_o,
    output logic                     mode_switch_done_o,
    output logic                     mode_err_o,
    input  logic [num_engines_p-1:0] eng_idle_i,
    bp_cce_msg_mode_switch_if.master msg
);
    localparam logic [lg_e_lp-1:0] reset_mode_lp  = lg_e_lp'(reset_mode_p);
    localparam logic [lg_e_lp:0]   num_engines_lp = (lg_e_lp + 1)'(num_engines_p);

    bp_cce_mode_switch_state_e state_q, state_d;
    logic [lg_e_lp-1:0]        mode_q, mode_d, target_q, target_d;
    logic                      done_q, done_d, err_q, err_d;
    logic                      req_open, chan_open;
    logic [cnt_width_lp-1:0]   out_cnt;
    logic                      out_full;

    bp_cce_msg_mode_switch_outstanding_counter #(
        .max_outstanding_p(max_outstanding_p)
    ) u_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .inc_i  (msg.mem_cmd_v & msg.mem_cmd_ready),
        .dec_i  (msg.mem_resp_yumi),
        .count_o(out_cnt),
        .full_o (out_full)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= e_ms_run;
            mode_q   <= reset_mode_lp;
            target_q <= reset_mode_lp;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            e_ms_run: begin
                if (mode_req_v_i) begin
                    if ({1'b0, mode_req_i} >= num_engines_lp) begin
                        err_d = 1'b1;
                    end else if (mode_req_i == mode_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = mode_req_i;
                        state_d  = e_ms_drain;
                    end
                end
            end
            e_ms_drain: begin
                // A pending outbound lce_cmd still belongs to the old engine, so wait it out too.
                if ((out_cnt == '0) && eng_idle_i[mode_q] && !msg.lce_cmd_v) begin
                    state_d = e_ms_switch;
                end
            end
            e_ms_switch: begin
                mode_d  = target_q;
                done_d  = 1'b1;
                state_d = e_ms_run;
            end
            default: state_d = e_ms_run;
        endcase
    end

    always_comb begin
        mode_req_ready_o = 1'b0;
        req_open         = 1'b0;
        chan_open        = 1'b0;
        unique case (state_q)
            e_ms_run:   begin mode_req_ready_o = 1'b1; req_open = 1'b1; chan_open = 1'b1; end
            e_ms_drain: chan_open = 1'b1;
            default:    ;
        endcase
    end

    assign active_mode_o      = mode_q;
    assign mode_switch_done_o = done_q;
    assign mode_err_o         = err_q;

    assign msg.lce_req_yumi  = msg.eng_lce_req_yumi[mode_q] & req_open;
    assign msg.lce_resp_yumi = msg.eng_lce_resp_yumi[mode_q] & chan_open;
    assign msg.mem_resp_yumi = msg.eng_mem_resp_yumi[mode_q] & chan_open;
    assign msg.lce_cmd       = msg.eng_lce_cmd[mode_q];
    assign msg.lce_cmd_v     = msg.eng_lce_cmd_v[mode_q] & chan_open;
    assign msg.mem_cmd       = msg.eng_mem_cmd[mode_q];
    assign msg.mem_cmd_v     = msg.eng_mem_cmd_v[mode_q] & chan_open & ~out_full;

    for (genvar gi = 0; gi < num_engines_p; gi++) begin : g_eng
        logic sel;
        assign sel = (mode_q == lg_e_lp'(gi));

        assign msg.eng_lce_req[gi]       = sel ? msg.lce_req  : lce_req_width_p'(0);
        assign msg.eng_lce_req_v[gi]     = sel & msg.lce_req_v & req_open;
        assign msg.eng_lce_resp[gi]      = sel ? msg.lce_resp : lce_resp_width_p'(0);
        assign msg.eng_lce_resp_v[gi]    = sel & msg.lce_resp_v & chan_open;
        assign msg.eng_mem_resp[gi]      = sel ? msg.mem_resp : mem_msg_width_p'(0);
        assign msg.eng_mem_resp_v[gi]    = sel & msg.mem_resp_v & chan_open;
        assign msg.eng_lce_cmd_ready[gi] = sel & msg.lce_cmd_ready & chan_open & (lce_cmd_width_p > 0);
        assign msg.eng_mem_cmd_ready[gi] = sel & msg.mem_cmd_ready & chan_open & ~out_full;
    end

endmodule
